// File: rtl/cdb_pkg.sv
// Shared types and widths for the common-data-bus arbiter.
// Slot payloads are stored at the package widths; keep module widths at or below them.
package cdb_pkg;
    localparam int CDB_DATA_W    = 32;
    localparam int CDB_TAG_W     = 4;
    localparam int CDB_MIN_UNITS = 2;
    localparam int CDB_MAX_UNITS = 8;

    typedef struct packed {
        logic [CDB_DATA_W-1:0] result;
        logic                  branch_taken;
        logic [CDB_TAG_W-1:0]  tag;
    } cdb_entry_t;

    // Next round-robin position after unit idx.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result ports and CDB broadcast, bundled for the arbiter.
// master = result producers side, slave = the arbiter.
interface cdb_arbiter_if #(
    parameter int NumUnits      = 4,
    parameter int DatapathWidth = 32,
    parameter int TagWidth      = 4
);
    logic [NumUnits-1:0]                    fu_valid_i;
    logic [NumUnits-1:0]                    fu_ready_o;
    logic [NumUnits-1:0][DatapathWidth-1:0] fu_result_i;
    logic [NumUnits-1:0]                    fu_branch_taken_i;
    logic [NumUnits-1:0][TagWidth-1:0]      fu_tag_i;
    logic                                   cdb_valid_o;
    logic [DatapathWidth-1:0]               cdb_result_o;
    logic                                   cdb_branch_taken_o;
    logic [TagWidth-1:0]                    cdb_tag_o;

    modport master (
        output fu_valid_i, fu_result_i, fu_branch_taken_i, fu_tag_i,
        input  fu_ready_o, cdb_valid_o, cdb_result_o, cdb_branch_taken_o, cdb_tag_o
    );

    modport slave (
        input  fu_valid_i, fu_result_i, fu_branch_taken_i, fu_tag_i,
        output fu_ready_o, cdb_valid_o, cdb_result_o, cdb_branch_taken_o, cdb_tag_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req, search begins at ptr.
// ptr moves past the winner only when advance is high.
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NumUnits = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumUnits-1:0] req,
    input  logic                advance,
    output logic [NumUnits-1:0] grant
);
    localparam int PtrW = $clog2(NumUnits);

    logic [PtrW-1:0] ptr;
    logic [PtrW-1:0] ptr_next;
    logic            found;

    // Two passes: units at/above ptr first, then wrap to the ones below it.
    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        for (int i = 0; i < NumUnits; i++) begin
            if (!found && i >= int'(ptr) && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                ptr_next = PtrW'(wrap_inc(i, NumUnits));
            end
        end
        for (int i = 0; i < NumUnits; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                ptr_next = PtrW'(wrap_inc(i, NumUnits));
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_next;
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per functional unit, round-robin
// broadcast of one result per cycle, flush drops everything still held.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NumUnits      = 4,
    parameter int DatapathWidth = CDB_DATA_W,
    parameter int TagWidth      = CDB_TAG_W
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    cdb_arbiter_if.slave   bus
);
    logic [NumUnits-1:0] held;
    logic [NumUnits-1:0] grant;
    logic [NumUnits-1:0] ready;
    logic [NumUnits-1:0] accept;
    cdb_entry_t          slot     [NumUnits];
    cdb_entry_t          incoming [NumUnits];
    cdb_entry_t          winner;
    cdb_entry_t          cdb_q;
    logic                cdb_valid;

    // A slot being granted this edge can take a new result in the same edge.
    assign ready  = (~held | grant) & {NumUnits{~flush_i}};
    assign accept = bus.fu_valid_i & ready;

    for (genvar u = 0; u < NumUnits; u++) begin : g_in
        assign incoming[u] = '{
            result:       CDB_DATA_W'(bus.fu_result_i[u]),
            branch_taken: bus.fu_branch_taken_i[u],
            tag:          CDB_TAG_W'(bus.fu_tag_i[u])
        };
    end

    rr_arbiter #(.NumUnits(NumUnits)) u_rr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (held),
        .advance (~flush_i),
        .grant   (grant)
    );

    always_comb begin
        winner = '0;
        for (int u = 0; u < NumUnits; u++) begin
            if (grant[u]) winner = slot[u];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held <= '0;
            for (int u = 0; u < NumUnits; u++) slot[u] <= '0;
        end else begin
            for (int u = 0; u < NumUnits; u++) begin
                if (flush_i) begin
                    held[u] <= 1'b0;
                end else if (accept[u]) begin
                    held[u] <= 1'b1;
                    slot[u] <= incoming[u];
                end else if (grant[u]) begin
                    held[u] <= 1'b0;
                end
            end
        end
    end

    // Payload registers keep their last value when nothing is broadcast.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cdb_valid <= 1'b0;
            cdb_q     <= '0;
        end else if (flush_i) begin
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= |grant;
            if (|grant) cdb_q <= winner;
        end
    end

    assign bus.fu_ready_o         = ready;
    assign bus.cdb_valid_o        = cdb_valid;
    assign bus.cdb_result_o       = DatapathWidth'(cdb_q.result);
    assign bus.cdb_branch_taken_o = cdb_q.branch_taken;
    assign bus.cdb_tag_o          = TagWidth'(cdb_q.tag);
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-cycle vector table for ready/valid/tag plus a
// broadcast scoreboard fed at handshake time and drained by a monitor.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NumUnits(N), .DatapathWidth(DW), .TagWidth(TW)) bus ();

    cdb_arbiter #(.NumUnits(N), .DatapathWidth(DW), .TagWidth(TW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    typedef struct {
        logic          flush;
        logic [N-1:0]  valid;
        logic [N-1:0]  exp_ready;
        logic          exp_cv;
        logic [TW-1:0] exp_tag;
    } row_t;

    typedef struct {
        logic [DW-1:0] result;
        logic          bt;
        logic [TW-1:0] tag;
    } exp_t;

    row_t          tbl[$];
    exp_t          sb[$];
    logic [DW-1:0] res [N];
    logic [TW-1:0] tg  [N];
    logic          bt  [N];
    int            sb_start = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic f, input logic [N-1:0] v, input logic [N-1:0] r,
                                input logic c, input logic [TW-1:0] t);
        row_t x;
        x.flush = f; x.valid = v; x.exp_ready = r; x.exp_cv = c; x.exp_tag = t;
        tbl.push_back(x);
    endfunction

    task automatic set_payload(input logic [DW-1:0] base);
        for (int u = 0; u < N; u++) begin
            res[u] = base + DW'(u * 256);
            tg[u]  = TW'(u);
            bt[u]  = u[0];
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic apply_row(input row_t r);
        exp_t e;
        flush = r.flush;
        for (int u = 0; u < N; u++) begin
            bus.fu_valid_i[u]        = r.valid[u];
            bus.fu_result_i[u]       = res[u];
            bus.fu_tag_i[u]          = tg[u];
            bus.fu_branch_taken_i[u] = bt[u];
        end
        @(negedge clk);
        chk("fu_ready", 32'(bus.fu_ready_o), 32'(r.exp_ready));
        chk("cdb_valid", 32'(bus.cdb_valid_o), 32'(r.exp_cv));
        if (r.exp_cv) chk("cdb_tag_order", 32'(bus.cdb_tag_o), 32'(r.exp_tag));
        // Simultaneous handshakes are queued in the order the arbiter should grant them.
        for (int k = 0; k < N; k++) begin
            int u;
            u = (sb_start + k) % N;
            if (r.valid[u] && r.exp_ready[u]) begin
                e.result = res[u]; e.bt = bt[u]; e.tag = tg[u];
                sb.push_back(e);
                res[u] = res[u] + 1;
            end
        end
        @(posedge clk);
        #1;
        if (r.flush) sb.delete();
    endtask

    task automatic run(input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) apply_row(tbl[i]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t m;
        if (!rst && bus.cdb_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cdb_unexpected: got broadcast tag %0d result %h, required none",
                         bus.cdb_tag_o, bus.cdb_result_o);
            end else begin
                m = sb.pop_front();
                chk("cdb_result", bus.cdb_result_o, m.result);
                chk("cdb_tag", 32'(bus.cdb_tag_o), 32'(m.tag));
                chk("cdb_branch", 32'(bus.cdb_branch_taken_o), 32'(m.bt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        int s_single, s_cont, s_fair, s_flush, s_refill, s_async_a, s_async_b;

        s_single = tbl.size();
        add(1'b0, 4'b0100, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'd5);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);

        s_cont = tbl.size();
        add(1'b0, 4'b1111, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b0001, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b0011, 1'b1, 4'd0);
        add(1'b0, 4'b0000, 4'b0111, 1'b1, 4'd1);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'd2);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'd3);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);

        s_fair = tbl.size();
        add(1'b0, 4'b1001, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b0111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'd3);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);

        s_flush = tbl.size();
        add(1'b0, 4'b0111, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b1001, 1'b0, 4'd0);
        add(1'b1, 4'b0000, 4'b0000, 1'b1, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b1111, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b0010, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b0110, 1'b1, 4'd1);
        add(1'b0, 4'b0000, 4'b1110, 1'b1, 4'd2);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'd3);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);

        s_refill = tbl.size();
        for (int r = 0; r < 10; r++)
            add(1'b0, (r < 8) ? 4'b0010 : 4'b0000, 4'b1111, (r >= 2), 4'd1);

        s_async_a = tbl.size();
        add(1'b0, 4'b0011, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b1101, 1'b0, 4'd0);

        s_async_b = tbl.size();
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b1001, 4'b1111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b0111, 1'b0, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'd0);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'd3);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0);

        // Reset state, flush masking ready during reset, handshakes ignored in reset.
        set_payload(32'h0000_7000);
        for (int u = 0; u < N; u++) begin
            bus.fu_valid_i[u]        = 1'b0;
            bus.fu_result_i[u]       = res[u];
            bus.fu_tag_i[u]          = tg[u];
            bus.fu_branch_taken_i[u] = bt[u];
        end
        #3;
        chk("rst_ready", 32'(bus.fu_ready_o), 32'hF);
        chk("rst_valid", 32'(bus.cdb_valid_o), 32'h0);
        chk("rst_result", bus.cdb_result_o, 32'h0);
        chk("rst_tag", 32'(bus.cdb_tag_o), 32'h0);
        chk("rst_branch", 32'(bus.cdb_branch_taken_o), 32'h0);
        flush = 1'b1;
        #1;
        chk("rst_flush_ready", 32'(bus.fu_ready_o), 32'h0);
        flush = 1'b0;
        bus.fu_valid_i = '1;
        @(posedge clk);
        @(negedge clk);
        bus.fu_valid_i = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        sb_start = 0;
        set_payload(32'h0000_1000);
        res[2] = 32'h0000_0010; tg[2] = 4'd5; bt[2] = 1'b0;
        run(s_single, 4);

        pulse_reset();
        set_payload(32'h0000_A000);
        run(s_cont, 7);

        set_payload(32'h0000_B000);
        run(s_fair, 5);

        set_payload(32'h0000_C000);
        run(s_flush, 5);
        sb_start = 1;
        run(s_flush + 5, 7);

        sb_start = 0;
        set_payload(32'h0000_D000);
        res[1] = 32'd1;
        run(s_refill, 10);
        @(negedge clk);
        chk("idle_valid", 32'(bus.cdb_valid_o), 32'h0);
        chk("idle_hold_result", bus.cdb_result_o, 32'd8);
        @(posedge clk);
        #1;

        // Reset lands mid-cycle while unit 0 is on the bus and unit 1 still waits.
        sb_start = 2;
        set_payload(32'h0000_E000);
        run(s_async_a, 2);
        #1;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(bus.cdb_valid_o), 32'h0);
        chk("async_ready", 32'(bus.fu_ready_o), 32'hF);
        chk("async_result", bus.cdb_result_o, 32'h0);
        chk("async_tag", 32'(bus.cdb_tag_o), 32'h0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb_start = 0;
        set_payload(32'h0000_F000);
        run(s_async_b, 7);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NumUnits, default 4, number of functional-unit result ports (2..8).
REQ-002 SHALL have parameter DatapathWidth, default 32, result width.
REQ-003 SHALL have parameter TagWidth, default 4, reorder/reservation tag width.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush_i  input  1  synchronous pipeline flush (mispredict).
REQ-007 SHALL have port fu_valid_i  input  NumUnits  per-unit result valid.
REQ-008 SHALL have port fu_ready_o  output  NumUnits  per-unit result accepted.
REQ-009 SHALL have port fu_result_i  input  NumUnits x DatapathWidth  per-unit result.
REQ-010 SHALL have port fu_branch_taken_i  input  NumUnits  per-unit branch outcome.
REQ-011 SHALL have port fu_tag_i  input  NumUnits x TagWidth  per-unit destination tag.
REQ-012 SHALL have port cdb_valid_o  output  1  broadcast valid, one cycle per result.
REQ-013 SHALL have port cdb_result_o  output  DatapathWidth  broadcast result.
REQ-014 SHALL have port cdb_branch_taken_o  output  1  broadcast branch outcome.
REQ-015 SHALL have port cdb_tag_o  output  TagWidth  broadcast tag.

Function
REQ-016 Each unit SHALL own a one-entry holding slot {held, result, branch_taken, tag}.
REQ-017 Handshake SHALL occur at an edge where fu_valid_i[i] && fu_ready_o[i] holds; the slot captures the payload and sets held.
REQ-018 fu_ready_o[i] SHALL equal (!held[i] || grant[i]) && !flush_i, combinational from state and flush_i only, never from fu_valid_i.
REQ-019 Arbitration SHALL be round-robin over held slots; grant is one-hot or zero, and the search starts at priority pointer ptr.
REQ-020 After a grant to unit i, ptr SHALL become (i+1) mod NumUnits; with no grant, ptr SHALL hold.
REQ-021 At the edge with grant[i], cdb_* registers SHALL load slot i, and cdb_valid_o SHALL be 1 in the following cycle. Held[i] SHALL clear unless a new handshake on i occurs at the same edge (refill, held stays 1).
REQ-022 With no held slot, cdb_valid_o SHALL be 0 next cycle; cdb_result_o, cdb_tag_o and cdb_branch_taken_o SHALL hold their previous values.
REQ-023 Latency SHALL be 2 edges minimum: accepted at edge k, broadcast valid in the cycle after edge k+1.
REQ-024 Throughput SHALL be one broadcast per cycle; the CDB has no backpressure.
REQ-025 A unit continuously valid SHALL sustain one result per cycle when alone, and one per NumUnits cycles when all units contend.
REQ-026 flush_i SHALL have priority: at the edge it is sampled, all held bits clear, cdb_valid_o goes 0, no grant takes effect, and no handshake is accepted; ptr holds.
REQ-027 No result SHALL be duplicated, dropped (except by flush) or reordered within one unit.

Reset
REQ-028 rst_i assertion SHALL immediately clear all held bits, cdb_valid_o, cdb_branch_taken_o, cdb_result_o, cdb_tag_o and ptr (to 0), independent of clk_i.
REQ-029 During reset, fu_ready_o SHALL read as all ones (slots empty) unless flush_i is 1; handshakes are ignored while rst_i is 1.
REQ-030 Reset asserted mid-operation SHALL discard all held results without broadcast.

Structure
REQ-031 Shared package cdb_pkg SHALL hold the cdb_entry_t struct (result, branch_taken, tag) and the width constants.
REQ-032 The round-robin arbiter SHALL be the sub-module rr_arbiter (inputs req, update/advance, clk_i, rst_i; output one-hot grant) owning ptr.

Verification
REQ-033 Single unit: unit 2 presents result 0x0000_0010, tag 5 for one cycle -> accepted same edge; cdb_valid_o=1 with 0x10/tag 5 exactly one cycle, 2 edges later.
REQ-034 Full contention: all 4 units valid at once from reset with tags 0..3 -> broadcasts tag order 0,1,2,3 on consecutive cycles; each fu_ready_o is low while its slot waits.
REQ-035 Fairness wrap: after unit 3 is granted, units 0 and 3 both request -> unit 0 granted first.
REQ-036 Refill: unit 1 holds valid every cycle with incrementing results 1..8, alone -> 8 back-to-back broadcasts, ready constantly 1, no gaps.
REQ-037 Flush: 3 slots held, flush_i pulsed one cycle -> no broadcast of those results, cdb_valid_o=0 next cycle, fu_ready_o all 0 during the flush cycle, all 1 after.
REQ-038 Async reset: rst_i asserted mid-cycle with 2 slots held -> cdb_valid_o drops before the next clock edge; no stale broadcast after release.
